// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg : shared constants and types for the interrupt controller  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package irq_pkg;

  localparam logic [1:0] CFG_MASK    = 2'd0;
  localparam logic [1:0] CFG_ENABLE  = 2'd1;
  localparam logic [1:0] CFG_PENDING = 2'd2;
  localparam logic [1:0] CFG_STATUS  = 2'd3;

  localparam int ID_W = 4;
  localparam logic [ID_W-1:0] PRI_NONE = 4'hF;

  typedef struct packed {
    logic [31:0]     pc;
    logic [ID_W-1:0] id;
  } irq_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } irq_state_e;

endpackage

`default_nettype wire

// File: rtl/irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// irq_priority_encoder : highest-set-index encoder over the eligible vector  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module irq_priority_encoder
  import irq_pkg::*;
#(
  parameter int N_IRQ = 3
) (
  input  logic [N_IRQ-1:0] req_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  idx_o
);

  // Ascending scan: the last set bit seen is the highest index.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (req_i[i]) begin
        idx_o = ID_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller : CP0-style interrupt controller with nested EPC stack  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module irq_controller
  import irq_pkg::*;
#(
  parameter int          N_IRQ      = 3,
  parameter int          NEST_DEPTH = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_IRQ-1:0]                irq_src_i,
  input  logic                            cfg_we_i,
  input  logic [1:0]                      cfg_addr_i,
  input  logic [31:0]                     cfg_wdata_i,
  output logic [31:0]                     cfg_rdata_o,
  input  logic [31:0]                     pc_next_i,
  output logic                            irq_req_o,
  output logic [31:0]                     irq_vector_o,
  input  logic                            irq_ack_i,
  input  logic                            eret_i,
  output logic [31:0]                     epc_o,
  output logic [$clog2(NEST_DEPTH):0]     depth_o
);

  localparam int DEPTH_W = $clog2(NEST_DEPTH) + 1;
  localparam int PTR_W   = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(NEST_DEPTH);

  logic [N_IRQ-1:0]   pending_q, pending_d;
  logic [N_IRQ-1:0]   mask_q;
  logic               enable_q;
  logic [N_IRQ-1:0]   prev_src_q;
  irq_state_e         state_q;
  logic               req_q;
  logic [ID_W-1:0]    id_q;
  logic [31:0]        vector_q;
  irq_entry_t         stack_q [NEST_DEPTH];
  logic [DEPTH_W-1:0] depth_q;

  logic [N_IRQ-1:0]   w_eligible;
  logic               w_cand_valid;
  logic [ID_W-1:0]    w_cand_id;
  logic [PTR_W-1:0]   w_top_idx;
  logic [PTR_W-1:0]   w_below_idx;
  logic               w_empty;
  logic               w_full;
  logic [ID_W-1:0]    w_cur_pri;
  logic               w_accept;
  logic               w_locked_elig;
  logic               w_locked_ok;
  logic               w_locked_ok_pop;
  logic               w_pop;
  logic               w_push;
  logic [N_IRQ-1:0]   w_id_onehot;
  logic [N_IRQ-1:0]   w_w1c;
  logic [N_IRQ-1:0]   w_ack_clr;
  irq_entry_t         w_new_entry;
  logic               w_unused;

  assign w_eligible = pending_q & ~mask_q & {N_IRQ{enable_q}};

  irq_priority_encoder #(
    .N_IRQ (N_IRQ)
  ) u_prio (
    .req_i   (w_eligible),
    .valid_o (w_cand_valid),
    .idx_o   (w_cand_id)
  );

  assign w_top_idx   = PTR_W'(depth_q - DEPTH_W'(1));
  assign w_below_idx = PTR_W'(depth_q - DEPTH_W'(2));
  assign w_empty     = (depth_q == '0);
  assign w_full      = (depth_q == DEPTH_MAX);
  assign w_cur_pri   = w_empty ? PRI_NONE : stack_q[w_top_idx].id;

  assign w_accept = w_cand_valid && (w_empty || (w_cand_id > w_cur_pri)) && !w_full;

  // The locked request is re-validated every cycle so it can be withdrawn.
  assign w_id_onehot     = N_IRQ'(1) << id_q;
  assign w_locked_elig   = |(w_eligible & w_id_onehot);
  assign w_locked_ok     = w_locked_elig && (w_empty || (id_q > w_cur_pri)) && !w_full;
  assign w_locked_ok_pop = w_locked_elig &&
                           ((depth_q == DEPTH_W'(1)) || (id_q > stack_q[w_below_idx].id));

  assign w_pop  = eret_i && !w_empty;
  assign w_push = (state_q == ST_REQ) && irq_ack_i && !eret_i;

  assign w_w1c       = (cfg_we_i && (cfg_addr_i == CFG_PENDING)) ? cfg_wdata_i[N_IRQ-1:0] : '0;
  assign w_ack_clr   = w_push ? w_id_onehot : '0;
  assign w_new_entry = '{pc: pc_next_i, id: id_q};

  // New edges are OR-ed in last so a same-cycle set wins over any clear.
  assign pending_d = (pending_q & ~w_w1c & ~w_ack_clr) | (irq_src_i & ~prev_src_q);

  assign w_unused = ^cfg_wdata_i[31:N_IRQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      mask_q     <= '0;
      enable_q   <= 1'b0;
      prev_src_q <= '0;
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      id_q       <= '0;
      vector_q   <= '0;
      depth_q    <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      pending_q  <= pending_d;
      prev_src_q <= irq_src_i;

      if (cfg_we_i && (cfg_addr_i == CFG_MASK)) begin
        mask_q <= cfg_wdata_i[N_IRQ-1:0];
      end
      if (cfg_we_i && (cfg_addr_i == CFG_ENABLE)) begin
        enable_q <= cfg_wdata_i[0];
      end

      if (w_pop) begin
        stack_q[w_top_idx] <= '0;
        depth_q            <= depth_q - DEPTH_W'(1);
      end else if (w_push) begin
        stack_q[PTR_W'(depth_q)] <= w_new_entry;
        depth_q                  <= depth_q + DEPTH_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            state_q  <= ST_REQ;
            req_q    <= 1'b1;
            id_q     <= w_cand_id;
            vector_q <= VEC_BASE + (32'(w_cand_id) * VEC_STRIDE);
          end
        end
        ST_REQ: begin
          // eret takes precedence; any ack in the same cycle is dropped.
          if (eret_i) begin
            if (w_pop ? !w_locked_ok_pop : !w_locked_ok) begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
            end
          end else if (irq_ack_i || !w_locked_ok) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      CFG_MASK:    cfg_rdata_o[N_IRQ-1:0] = mask_q;
      CFG_ENABLE:  cfg_rdata_o[0]         = enable_q;
      CFG_PENDING: cfg_rdata_o[N_IRQ-1:0] = pending_q;
      default: begin
        cfg_rdata_o[15:8] = 8'(depth_q);
        cfg_rdata_o[7:4]  = w_cur_pri;
        cfg_rdata_o[3]    = req_q;
        cfg_rdata_o[2:0]  = id_q[2:0];
      end
    endcase
  end

  assign irq_req_o    = req_q;
  assign irq_vector_o = vector_q;
  assign epc_o        = w_empty ? 32'h0 : stack_q[w_top_idx].pc;
  assign depth_o      = depth_q;

endmodule

`default_nettype wire

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Coprocessor-0 style interrupt controller for the single-cycle MIPS core; replaces the ad-hoc interrupt_signs/mask/disable/epc logic.
- Edge-detects external interrupt lines into a pending register and applies a mask and a global enable.
- Arbitrates by fixed priority and drives a request/acknowledge handshake that redirects the PC.
- Keeps a nested EPC stack for preemption by higher-priority sources and for eret.

Parameters:
- N_IRQ, 3, number of interrupt sources; index N_IRQ-1 has the highest priority.
- NEST_DEPTH, 4, EPC stack entries, i.e. maximum nesting depth.
- VEC_BASE, 32'h0000_0000, vector address of source 0.
- VEC_STRIDE, 32'h0000_0010, byte spacing between vectors.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- irq_src  in  N_IRQ  raw interrupt lines, synchronous to clk.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  2  register select: 0=MASK, 1=ENABLE, 2=PENDING (write-1-to-clear), 3=STATUS (read-only).
- cfg_wdata  in  32  write data.
- cfg_rdata  out  32  combinational read of the register at cfg_addr.
- pc_next  in  32  address the core would execute next; saved on acknowledge.
- irq_req  out  1  interrupt redirect request.
- irq_vector  out  32  target PC; valid while irq_req=1.
- irq_ack  in  1  core took the redirect this cycle.
- eret  in  1  return from interrupt.
- epc  out  32  top-of-stack return address; 0 when the stack is empty.
- depth  out  log2(NEST_DEPTH)+1  current nesting level.

Behaviour:
- Reset (async assert, sync release) clears: pending=0, mask=0, enable=0, prev_src=0, irq_req=0, irq_vector=0, depth=0, all stack entries=0. Hence epc=0 and cfg_rdata depends only on cfg_addr.
- Edge detect: pending[i] sets on an irq_src[i] 0->1 transition (prev_src vs irq_src). A level held high sets pending only once.
- Set beats clear: if a W1C clear and a new edge hit the same bit in one cycle, the bit stays set.
- eligible = pending & ~mask, gated by enable[0].
- Candidate: the highest set index of eligible.
- cur_pri: id of the top stack entry, or "none" when depth=0.
- Accept condition: candidate exists AND (depth=0 OR candidate > cur_pri) AND depth < NEST_DEPTH.
- Handshake, state IDLE:
  - If the accept condition holds, next cycle irq_req=1, locked id = candidate, irq_vector = VEC_BASE + id*VEC_STRIDE. Go to REQ.
  - Latency: edge on irq_src to irq_req is 2 cycles (edge captured into pending, then request registered).
- Handshake, state REQ:
  - irq_vector and the locked id hold stable. A later higher-priority arrival does not change them.
  - irq_ack=1 (and eret=0): push {pc_next, id}, clear pending[id], depth+1, irq_req=0 next cycle. Go to IDLE.
  - Withdraw: if the locked id stops satisfying the accept condition (masked, disabled, or W1C-cleared) before ack, irq_req=0 next cycle. Go to IDLE.
- irq_ack while irq_req=0 is ignored.
- eret with depth>0 pops the top entry; epc then shows the new top.
- eret with depth=0 is ignored.
- eret and irq_ack in the same cycle: eret executes and the ack is ignored. irq_req stays high if the accept condition still holds against the popped state.
- Stack full (depth=NEST_DEPTH): no new request; pending bits keep accumulating.
- STATUS read: [31:16]=0, [15:8]=depth, [7:4]=cur_pri (4'hF when none), [3]=irq_req, [2:0]=locked id.
- MASK, ENABLE and PENDING reads return their N_IRQ-bit or 1-bit values zero-extended.
- CPU integration: when irq_ack=1, pc_in = irq_vector. The core redirects to epc on eret.

Decomposition:
- Shared package irq_pkg: cfg address constants (CFG_MASK, CFG_ENABLE, CFG_PENDING, CFG_STATUS), PRI_NONE = 4'hF, and the stack entry struct {pc[31:0], id[3:0]}.
- One sub-module, irq_priority_encoder: parameterised N_IRQ, takes the eligible vector and outputs valid plus the highest set index.
- The stack and FSM stay in irq_controller.

Test Plan:
- Post-reset: enable=0, pulse irq_src[1] -> pending=3'b010, irq_req stays 0. Write ENABLE=1 -> irq_req=1 after 1 cycle, irq_vector=32'h10.
- Ack with pc_next=32'h40 -> depth=1, epc=32'h40, pending[1]=0. eret -> depth=0, epc=0.
- Nesting: in service id 1, edge on src 2 -> req with vector 32'h20. Ack with pc_next=32'h14 -> depth=2, epc=32'h14. Edge on src 0 -> no req until both erets, then vector 32'h0.
- Withdraw: irq_req=1 for id 2, write MASK=3'b100 before ack -> irq_req=0 next cycle, pending[2] still 1. Unmask -> request returns.
- Same-cycle: W1C clear of bit 0 plus src 0 edge -> pending[0]=1. eret+ack together at depth 1 -> depth=0, ack ignored.
- Fill NEST_DEPTH=4 with ascending priorities (N_IRQ=5 build) -> fifth edge gives no req. Async rst_n low mid-REQ -> irq_req=0 and depth=0 immediately.
